traffic_light_checker: RTL

Sequence checker on the receiving end of the 3-bit one-hot `light` bus produced by the intersection traffic-light controller. It locks onto the RED→YELLOW→GREEN→RED cycle, tracks how many cycles each colour is held, and flags illegal codes, out-of-order transitions and dwell violations. It also keeps a saturating error count. It sits beside the controller, either in the intersection top level or as a bench-reusable monitor.

---
 rtl/traffic_pkg.sv | 31 +++
 rtl/sat_counter.sv | 29 ++
 rtl/traffic_light_checker.sv | 119 +++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared colour encoding, sequence helpers and checker state encoding for the traffic-light blocks.
package traffic_pkg;

  localparam int unsigned LIGHT_W = 3;

  localparam logic [LIGHT_W-1:0] RED    = 3'b100;
  localparam logic [LIGHT_W-1:0] YELLOW = 3'b010;
  localparam logic [LIGHT_W-1:0] GREEN  = 3'b001;

  localparam int unsigned STATE_W = 1;
  localparam logic [STATE_W-1:0] SYNC   = 1'b0;
  localparam logic [STATE_W-1:0] LOCKED = 1'b1;

  // Colour that legally follows c; anything unexpected restarts at RED.
  function automatic logic [LIGHT_W-1:0] next_color(input logic [LIGHT_W-1:0] c);
    logic [LIGHT_W-1:0] n;
    case (c)
      RED:     n = YELLOW;
      YELLOW:  n = GREEN;
      GREEN:   n = RED;
      default: n = RED;
    endcase
    return n;
  endfunction

  // True only for the three legal colour codes.
  function automatic logic is_onehot(input logic [LIGHT_W-1:0] v);
    return (v == RED) || (v == YELLOW) || (v == GREEN);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with clear, load-to-one and optional saturation at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             load1,
  input  logic             clear,
  input  logic             saturate,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  // Priority: clear, then load-1, then increment (held at max when saturating).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load1) begin
      count <= WIDTH'(1);
    end else if (inc && !(saturate && (count == MAX_VAL))) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/traffic_light_checker.sv
// Monitors the one-hot light bus, locks onto RED->YELLOW->GREEN and flags code, order and dwell errors.
module traffic_light_checker
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_DWELL = 1,
  parameter int unsigned MAX_DWELL = 1,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       light,
  input  logic             enable,
  input  logic             clear_err,
  output logic             locked,
  output logic [2:0]       expected,
  output logic [CNT_W-1:0] dwell,
  output logic             onehot_err,
  output logic             seq_err,
  output logic             dwell_err,
  output logic [7:0]       err_count
);

  localparam int unsigned ERR_W = 8;
  localparam logic [CNT_W-1:0] MIN_D = CNT_W'(MIN_DWELL);
  localparam logic [CNT_W-1:0] MAX_D = CNT_W'(MAX_DWELL);

  logic [STATE_W-1:0] state_q, state_d;
  logic [2:0]         cur_q, cur_d;
  logic [2:0]         exp_q, exp_d;
  logic               oh_d, seq_d, dw_d;
  logic               dwell_inc, dwell_load, dwell_clr;
  logic               err_inc, err_clr;

  // State, colour and pulse registers; pulses follow the decode of the current sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= SYNC;
      cur_q      <= RED;
      exp_q      <= RED;
      onehot_err <= 1'b0;
      seq_err    <= 1'b0;
      dwell_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      exp_q      <= exp_d;
      onehot_err <= oh_d;
      seq_err    <= seq_d;
      dwell_err  <= dw_d;
    end
  end

  // Next-state decode of the sampled colour; nothing moves while enable is low.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    exp_d      = exp_q;
    oh_d       = 1'b0;
    seq_d      = 1'b0;
    dw_d       = 1'b0;
    dwell_inc  = 1'b0;
    dwell_load = 1'b0;
    dwell_clr  = 1'b0;
    if (enable) begin
      if (state_q == SYNC) begin
        if (light == RED) begin
          state_d    = LOCKED;
          cur_d      = RED;
          exp_d      = next_color(RED);
          dwell_load = 1'b1;
        end
      end else begin
        if (light == cur_q) begin
          dwell_inc = 1'b1;
          // Fires only on the step past the limit, so a stuck colour reports once.
          if (dwell == MAX_D) dw_d = 1'b1;
        end else if (light == next_color(cur_q)) begin
          cur_d      = light;
          exp_d      = next_color(light);
          dwell_load = 1'b1;
          if (dwell < MIN_D) dw_d = 1'b1;
        end else begin
          if (!is_onehot(light)) oh_d = 1'b1;
          else                   seq_d = 1'b1;
          state_d   = SYNC;
          cur_d     = RED;
          exp_d     = RED;
          dwell_clr = 1'b1;
        end
      end
    end
  end

  assign err_inc  = oh_d | seq_d | dw_d;
  assign err_clr  = clear_err & enable;
  assign locked   = state_q;
  assign expected = exp_q;

  sat_counter #(.WIDTH(CNT_W)) u_dwell_cnt (
    .clk      (clk),
    .reset    (reset),
    .inc      (dwell_inc),
    .load1    (dwell_load),
    .clear    (dwell_clr),
    .saturate (1'b1),
    .count    (dwell)
  );

  sat_counter #(.WIDTH(ERR_W)) u_err_cnt (
    .clk      (clk),
    .reset    (reset),
    .inc      (err_inc),
    .load1    (1'b0),
    .clear    (err_clr),
    .saturate (1'b1),
    .count    (err_count)
  );

endmodule
